// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types for the two-port AXI read arbiter.
package axi_rd_arbiter_pkg;

  // Number of upstream requesters sharing the controller read port.
  localparam int NPORTS = 2;

  // Upstream port identity; also the tag bit prepended to the request ID.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

endpackage

// File: rtl/axi_rd_arbiter.sv
// Two-port AXI4 read-channel arbiter: round-robin AR grant through a single
// registered request slot, source-tagged IDs, and tag-based R routing.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ADDRS    = 27,
  parameter int REQID    = 4,
  parameter int MAX_PEND = 4
) (
  input  logic               clock,
  input  logic               reset,
  // upstream port 0
  input  logic               s0_arvalid_i,
  output logic               s0_arready_o,
  input  logic [ADDRS-1:0]   s0_araddr_i,
  input  logic [REQID-1:0]   s0_arid_i,
  input  logic [7:0]         s0_arlen_i,
  input  logic [1:0]         s0_arburst_i,
  output logic               s0_rvalid_o,
  input  logic               s0_rready_i,
  output logic               s0_rlast_o,
  output logic [1:0]         s0_rresp_o,
  output logic [REQID-1:0]   s0_rid_o,
  output logic [WIDTH-1:0]   s0_rdata_o,
  // upstream port 1
  input  logic               s1_arvalid_i,
  output logic               s1_arready_o,
  input  logic [ADDRS-1:0]   s1_araddr_i,
  input  logic [REQID-1:0]   s1_arid_i,
  input  logic [7:0]         s1_arlen_i,
  input  logic [1:0]         s1_arburst_i,
  output logic               s1_rvalid_o,
  input  logic               s1_rready_i,
  output logic               s1_rlast_o,
  output logic [1:0]         s1_rresp_o,
  output logic [REQID-1:0]   s1_rid_o,
  output logic [WIDTH-1:0]   s1_rdata_o,
  // downstream controller port
  output logic               m_arvalid_o,
  input  logic               m_arready_i,
  output logic [ADDRS-1:0]   m_araddr_o,
  output logic [REQID:0]     m_arid_o,
  output logic [7:0]         m_arlen_o,
  output logic [1:0]         m_arburst_o,
  input  logic               m_rvalid_i,
  output logic               m_rready_o,
  input  logic               m_rlast_i,
  input  logic [1:0]         m_rresp_i,
  input  logic [REQID:0]     m_rid_i,
  input  logic [WIDTH-1:0]   m_rdata_i
);

  // Counters are 4 bits wide, so MAX_PEND is limited to 15.
  localparam logic [3:0] PEND_LIMIT = 4'(MAX_PEND);

  // Round-robin pick: returns {grant_valid, granted_port}.
  function automatic logic [1:0] rr_pick(input logic [1:0] el, input port_e last);
    logic [1:0] res;
    case (el)
      2'b01:   res = 2'b10;
      2'b10:   res = 2'b11;
      2'b11:   res = {1'b1, ~last};
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  logic [NPORTS-1:0] arvalid;
  logic [NPORTS-1:0] elig;
  logic [NPORTS-1:0] ar_fire;
  logic [NPORTS-1:0] r_done;
  logic [NPORTS-1:0] gnt_onehot;
  logic [NPORTS-1:0] r_sel_onehot;

  logic       gnt_valid;
  port_e      gnt_port;
  logic       can_load;
  logic       load;
  logic       r_sel;
  logic       r_last_hs;

  logic             slot_valid_q, slot_valid_d;
  port_e            slot_port_q,  slot_port_d;
  logic [ADDRS-1:0] slot_addr_q,  slot_addr_d;
  logic [REQID-1:0] slot_id_q,    slot_id_d;
  logic [7:0]       slot_len_q,   slot_len_d;
  logic [1:0]       slot_burst_q, slot_burst_d;
  port_e            last_gnt_q,   last_gnt_d;

  assign arvalid = {s1_arvalid_i, s0_arvalid_i};

  // Grant selection among eligible ports, alternating on contention.
  always_comb begin
    logic [1:0] pick;
    pick      = rr_pick(elig, last_gnt_q);
    gnt_valid = pick[1];
    gnt_port  = port_e'(pick[0]);
  end

  // The slot accepts a new request when empty or draining this cycle;
  // reset forces arready low so nothing is accepted while it is held.
  assign can_load   = ~slot_valid_q | m_arready_i;
  assign load       = can_load & gnt_valid & ~reset;
  assign gnt_onehot = {gnt_port == PORT1, gnt_port == PORT0};
  assign ar_fire    = {NPORTS{load}} & gnt_onehot;

  assign s0_arready_o = ar_fire[0];
  assign s1_arready_o = ar_fire[1];

  // Next-state for the request slot and the round-robin pointer.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_port_d  = slot_port_q;
    slot_addr_d  = slot_addr_q;
    slot_id_d    = slot_id_q;
    slot_len_d   = slot_len_q;
    slot_burst_d = slot_burst_q;
    last_gnt_d   = last_gnt_q;
    if (can_load) begin
      slot_valid_d = gnt_valid;
    end
    if (load) begin
      slot_port_d = gnt_port;
      last_gnt_d  = gnt_port;
      if (gnt_port == PORT1) begin
        slot_addr_d  = s1_araddr_i;
        slot_id_d    = s1_arid_i;
        slot_len_d   = s1_arlen_i;
        slot_burst_d = s1_arburst_i;
      end else begin
        slot_addr_d  = s0_araddr_i;
        slot_id_d    = s0_arid_i;
        slot_len_d   = s0_arlen_i;
        slot_burst_d = s0_arburst_i;
      end
    end
  end

  // Slot registers; last_gnt resets to port 1 so port 0 wins first contention.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid_q <= 1'b0;
      slot_port_q  <= PORT0;
      slot_addr_q  <= '0;
      slot_id_q    <= '0;
      slot_len_q   <= '0;
      slot_burst_q <= '0;
      last_gnt_q   <= PORT1;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_port_q  <= slot_port_d;
      slot_addr_q  <= slot_addr_d;
      slot_id_q    <= slot_id_d;
      slot_len_q   <= slot_len_d;
      slot_burst_q <= slot_burst_d;
      last_gnt_q   <= last_gnt_d;
    end
  end

  assign m_arvalid_o = slot_valid_q;
  assign m_araddr_o  = slot_addr_q;
  assign m_arid_o    = {slot_port_q, slot_id_q};
  assign m_arlen_o   = slot_len_q;
  assign m_arburst_o = slot_burst_q;

  // R routing: the ID tag bit picks the owning port, no buffering.
  assign r_sel        = m_rid_i[REQID];
  assign r_sel_onehot = {r_sel, ~r_sel};
  assign m_rready_o   = r_sel ? s1_rready_i : s0_rready_i;
  assign r_last_hs    = m_rvalid_i & m_rready_o & m_rlast_i;
  assign r_done       = {NPORTS{r_last_hs}} & r_sel_onehot;

  assign s0_rvalid_o = m_rvalid_i & ~r_sel;
  assign s1_rvalid_o = m_rvalid_i & r_sel;
  assign s0_rid_o    = m_rid_i[REQID-1:0];
  assign s1_rid_o    = m_rid_i[REQID-1:0];
  assign s0_rdata_o  = m_rdata_i;
  assign s1_rdata_o  = m_rdata_i;
  assign s0_rresp_o  = m_rresp_i;
  assign s1_rresp_o  = m_rresp_i;
  assign s0_rlast_o  = m_rlast_i;
  assign s1_rlast_o  = m_rlast_i;

  // Per-port outstanding-burst counters gating eligibility.
  for (genvar gi = 0; gi < NPORTS; gi++) begin : gen_pend
    logic [3:0] pend_q, pend_d;

    assign elig[gi] = arvalid[gi] & (pend_q < PEND_LIMIT);

    // Count up on accepted AR, down on final R beat; both cancel out.
    always_comb begin
      pend_d = pend_q;
      case ({ar_fire[gi], r_done[gi]})
        2'b10:   pend_d = pend_q + 4'd1;
        2'b01:   pend_d = pend_q - 4'd1;
        default: pend_d = pend_q;
      endcase
    end

    // Counter register.
    always_ff @(posedge clock) begin
      if (reset) begin
        pend_q <= 4'd0;
      end else begin
        pend_q <= pend_d;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with AR/R scoreboards (MAX_PEND = 2).
module tb_axi_rd_arbiter;

  typedef struct packed {
    logic [4:0]  id;
    logic [26:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
  } ar_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic        last;
  } r_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
  logic [26:0] s0_araddr;
  logic [3:0]  s0_arid, s0_rid;
  logic [7:0]  s0_arlen;
  logic [1:0]  s0_arburst, s0_rresp;
  logic [31:0] s0_rdata;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
  logic [26:0] s1_araddr;
  logic [3:0]  s1_arid, s1_rid;
  logic [7:0]  s1_arlen;
  logic [1:0]  s1_arburst, s1_rresp;
  logic [31:0] s1_rdata;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [26:0] m_araddr;
  logic [4:0]  m_arid, m_rid;
  logic [7:0]  m_arlen;
  logic [1:0]  m_arburst, m_rresp;
  logic [31:0] m_rdata;

  int n_cmp = 0;
  int n_mis = 0;

  ar_t ar_q[$];
  r_t  r0_q[$];
  r_t  r1_q[$];

  axi_rd_arbiter #(.WIDTH(32), .ADDRS(27), .REQID(4), .MAX_PEND(2)) dut (
    .clock(clk), .reset(rst),
    .s0_arvalid_i(s0_arvalid), .s0_arready_o(s0_arready), .s0_araddr_i(s0_araddr),
    .s0_arid_i(s0_arid), .s0_arlen_i(s0_arlen), .s0_arburst_i(s0_arburst),
    .s0_rvalid_o(s0_rvalid), .s0_rready_i(s0_rready), .s0_rlast_o(s0_rlast),
    .s0_rresp_o(s0_rresp), .s0_rid_o(s0_rid), .s0_rdata_o(s0_rdata),
    .s1_arvalid_i(s1_arvalid), .s1_arready_o(s1_arready), .s1_araddr_i(s1_araddr),
    .s1_arid_i(s1_arid), .s1_arlen_i(s1_arlen), .s1_arburst_i(s1_arburst),
    .s1_rvalid_o(s1_rvalid), .s1_rready_i(s1_rready), .s1_rlast_o(s1_rlast),
    .s1_rresp_o(s1_rresp), .s1_rid_o(s1_rid), .s1_rdata_o(s1_rdata),
    .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_araddr_o(m_araddr),
    .m_arid_o(m_arid), .m_arlen_o(m_arlen), .m_arburst_o(m_arburst),
    .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rlast_i(m_rlast),
    .m_rresp_i(m_rresp), .m_rid_i(m_rid), .m_rdata_i(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_arvalid = 0; s0_araddr = '0; s0_arid = '0; s0_arlen = '0; s0_arburst = '0; s0_rready = 1;
    s1_arvalid = 0; s1_araddr = '0; s1_arid = '0; s1_arlen = '0; s1_arburst = '0; s1_rready = 1;
    m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rresp = '0; m_rid = '0; m_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    tick();
    tick();
    ar_q.delete();
    r0_q.delete();
    r1_q.delete();
    rst = 0;
  endtask

  // Scoreboard: every downstream AR and upstream R handshake pops one entry.
  always @(negedge clk) begin
    ar_t ea;
    r_t  er;
    if (!rst) begin
      if (m_arvalid && m_arready) begin
        if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
        else begin
          ea = ar_q.pop_front();
          $display("AR  id=0x%02h addr=0x%07h len=%0d burst=%0d", m_arid, m_araddr, m_arlen, m_arburst);
          check("m_arid", m_arid, ea.id);
          check("m_araddr", m_araddr, ea.addr);
          check("m_arlen", m_arlen, ea.len);
          check("m_arburst", m_arburst, ea.burst);
        end
      end
      if (s0_rvalid && s0_rready) begin
        if (r0_q.size() == 0) check("r0_unexpected", 1, 0);
        else begin
          er = r0_q.pop_front();
          $display("R0  id=0x%0h data=0x%08h last=%0b", s0_rid, s0_rdata, s0_rlast);
          check("s0_rid", s0_rid, er.id);
          check("s0_rdata", s0_rdata, er.data);
          check("s0_rlast", s0_rlast, er.last);
        end
      end
      if (s1_rvalid && s1_rready) begin
        if (r1_q.size() == 0) check("r1_unexpected", 1, 0);
        else begin
          er = r1_q.pop_front();
          $display("R1  id=0x%0h data=0x%08h last=%0b", s1_rid, s1_rdata, s1_rlast);
          check("s1_rid", s1_rid, er.id);
          check("s1_rdata", s1_rdata, er.data);
          check("s1_rlast", s1_rlast, er.last);
        end
      end
    end
  end

  initial begin
    // Reset state, with both requesters already asserting arvalid.
    clear_inputs();
    s0_arvalid = 1;
    s1_arvalid = 1;
    tick();
    @(negedge clk);
    check("rst_m_arvalid", m_arvalid, 0);
    check("rst_s0_arready", s0_arready, 0);
    check("rst_s1_arready", s1_arready, 0);
    tick();
    s0_arvalid = 0;
    s1_arvalid = 0;
    rst = 0;

    // Single read on port 0, four-beat burst returned.
    s0_araddr = 27'h10; s0_arid = 4'd3; s0_arlen = 8'd3; s0_arburst = 2'd1;
    s0_arvalid = 1; m_arready = 1;
    ar_q.push_back('{5'h03, 27'h10, 8'd3, 2'd1});
    @(negedge clk);
    check("single_s0_arready", s0_arready, 1);
    check("single_s1_arready", s1_arready, 0);
    tick();
    s0_arvalid = 0;
    @(negedge clk);
    check("single_latency", m_arvalid, 1);
    tick();
    @(negedge clk);
    check("single_drained", m_arvalid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      m_rvalid = 1; m_rid = 5'h03; m_rdata = 32'hA000_0000 + i; m_rlast = (i == 3); m_rresp = 2'd0;
      r0_q.push_back('{4'h3, 32'hA000_0000 + i, (i == 3)});
      @(negedge clk);
      check("single_s1_rvalid", s1_rvalid, 0);
      check("single_m_rready", m_rready, 1);
    end
    tick();
    m_rvalid = 0; m_rlast = 0;

    // Contention from reset: grants alternate 0,1,0,1 then both hit the limit.
    do_reset();
    s0_araddr = 27'h100; s0_arid = 4'd1; s0_arlen = 8'd0; s0_arburst = 2'd1;
    s1_araddr = 27'h200; s1_arid = 4'd2; s1_arlen = 8'd1; s1_arburst = 2'd1;
    s0_arvalid = 1; s1_arvalid = 1; m_arready = 1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      if (k % 2 == 0) ar_q.push_back('{5'h01, 27'h100, 8'd0, 2'd1});
      else            ar_q.push_back('{5'h12, 27'h200, 8'd1, 2'd1});
      @(negedge clk);
      check("cont_s0_arready", s0_arready, (k % 2 == 0));
      check("cont_s1_arready", s1_arready, (k % 2 == 1));
    end
    tick();
    @(negedge clk);
    check("cont_full_s0", s0_arready, 0);
    check("cont_full_s1", s1_arready, 0);
    tick();
    s0_arvalid = 0; s1_arvalid = 0;
    @(negedge clk);
    check("cont_slot_empty", m_arvalid, 0);

    // Downstream backpressure: slot holds steady, no upstream accepts.
    do_reset();
    s0_araddr = 27'h30; s0_arid = 4'd5; s0_arlen = 8'd7; s0_arburst = 2'd2;
    s0_arvalid = 1; m_arready = 0;
    ar_q.push_back('{5'h05, 27'h30, 8'd7, 2'd2});
    @(negedge clk);
    check("bp_load_s0", s0_arready, 1);
    tick();
    s0_arvalid = 0;
    s1_araddr = 27'h40; s1_arid = 4'd6; s1_arlen = 8'd2; s1_arburst = 2'd1;
    s1_arvalid = 1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      check("bp_s0_arready", s0_arready, 0);
      check("bp_s1_arready", s1_arready, 0);
      check("bp_arvalid", m_arvalid, 1);
      check("bp_araddr", m_araddr, 27'h30);
      check("bp_arid", m_arid, 5'h05);
    end
    tick();
    m_arready = 1;
    ar_q.push_back('{5'h16, 27'h40, 8'd2, 2'd1});
    @(negedge clk);
    check("bp_release_s1", s1_arready, 1);
    tick();
    s1_arvalid = 0;
    @(negedge clk);
    check("bp_next_xfer", m_arvalid, 1);
    tick();
    @(negedge clk);
    check("bp_done", m_arvalid, 0);

    // Pending limit on port 1; port 0 keeps access while port 1 is full.
    do_reset();
    m_arready = 1;
    s1_araddr = 27'h50; s1_arid = 4'd7; s1_arlen = 8'd0; s1_arburst = 2'd1;
    s1_arvalid = 1;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) tick();
      ar_q.push_back('{5'h17, 27'h50, 8'd0, 2'd1});
      @(negedge clk);
      check("lim_accept", s1_arready, 1);
    end
    tick();
    @(negedge clk);
    check("lim_full", s1_arready, 0);
    tick();
    m_rvalid = 1; m_rid = 5'h17; m_rlast = 1; m_rdata = 32'hB0;
    r1_q.push_back('{4'h7, 32'hB0, 1'b1});
    @(negedge clk);
    check("lim_full_at_rlast", s1_arready, 0);
    check("lim_s0_rvalid", s0_rvalid, 0);
    tick();
    m_rvalid = 0; m_rlast = 0;
    ar_q.push_back('{5'h17, 27'h50, 8'd0, 2'd1});
    @(negedge clk);
    check("lim_release", s1_arready, 1);
    s0_araddr = 27'h60; s0_arid = 4'd9; s0_arlen = 8'd0; s0_arburst = 2'd1;
    for (int k = 0; k < 2; k++) begin
      tick();
      s0_arvalid = 1;
      ar_q.push_back('{5'h09, 27'h60, 8'd0, 2'd1});
      @(negedge clk);
      check("lim_other_s0", s0_arready, 1);
      check("lim_other_s1", s1_arready, 0);
    end

    // R backpressure on port 1: m_rready follows s1_rready exactly.
    tick();
    s0_arvalid = 0; s1_arvalid = 0;
    m_rvalid = 1; m_rid = 5'h17; m_rlast = 0; s0_rready = 1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      s1_rready = (c % 2 == 1);
      m_rdata = 32'hC0 + c;
      if (c % 2 == 1) r1_q.push_back('{4'h7, 32'hC0 + c, 1'b0});
      @(negedge clk);
      check("rbp_m_rready", m_rready, (c % 2 == 1));
      check("rbp_s0_rvalid", s0_rvalid, 0);
      check("rbp_s1_rvalid", s1_rvalid, 1);
    end
    tick();
    m_rvalid = 0; s1_rready = 1;

    // Reset mid-operation with pend = {2,1} and a stalled slot.
    do_reset();
    m_arready = 1;
    s0_araddr = 27'h70; s0_arid = 4'd1; s0_arlen = 8'd0; s0_arburst = 2'd1;
    s1_araddr = 27'h80; s1_arid = 4'd2; s1_arlen = 8'd0; s1_arburst = 2'd1;
    s0_arvalid = 1; s1_arvalid = 1;
    ar_q.push_back('{5'h01, 27'h70, 8'd0, 2'd1});
    @(negedge clk);
    check("mid_g0", s0_arready, 1);
    tick();
    ar_q.push_back('{5'h12, 27'h80, 8'd0, 2'd1});
    @(negedge clk);
    check("mid_g1", s1_arready, 1);
    tick();
    s1_arvalid = 0;
    ar_q.push_back('{5'h01, 27'h70, 8'd0, 2'd1});
    @(negedge clk);
    check("mid_g2", s0_arready, 1);
    tick();
    s0_arvalid = 0; m_arready = 0; rst = 1;
    @(negedge clk);
    check("mid_rst_s0_arready", s0_arready, 0);
    check("mid_rst_s1_arready", s1_arready, 0);
    tick();
    @(negedge clk);
    check("mid_rst_slot_clear", m_arvalid, 0);
    ar_q.delete();
    tick();
    rst = 0;
    s0_arvalid = 1; s1_arvalid = 1; m_arready = 1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      if (k % 2 == 0) ar_q.push_back('{5'h01, 27'h70, 8'd0, 2'd1});
      else            ar_q.push_back('{5'h12, 27'h80, 8'd0, 2'd1});
      @(negedge clk);
      check("post_rst_s0", s0_arready, (k % 2 == 0));
      check("post_rst_s1", s1_arready, (k % 2 == 1));
    end
    tick();
    s0_arvalid = 0; s1_arvalid = 0;
    tick();
    tick();
    @(negedge clk);
    check("ar_q_drained", ar_q.size(), 0);
    check("r0_q_drained", r0_q.size(), 0);
    check("r1_q_drained", r1_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
